load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit that sits directly upstream of the register file write port in the NPC core. It accepts one memory instruction at a time from execute, drives a valid/ready memory request channel, and waits for the response. For loads it aligns and sign/zero-extends the returned word and produces the register file write triple (`rf_wen`, `rf_waddr`, `rf_wdata`). Stores produce byte-lane masked writes and no register write.

## Interface
- `ADDR_WIDTH`, default 5: register index width.
- `DATA_WIDTH`, default 32: data and address width. Lane logic is defined for 32 only.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  execute presents a memory op.
- `req_ready`  out  1  unit can accept an op. High only in IDLE.
- `req_is_load`  in  1  1 = load, 0 = store.
- `req_funct3`  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `req_addr`  in  DATA_WIDTH  effective byte address.
- `req_wdata`  in  DATA_WIDTH  store data (rs2).
- `req_rd`  in  ADDR_WIDTH  load destination register.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_addr`  out  DATA_WIDTH  word-aligned address (`addr[1:0]` = 00).
- `mem_req_wen`  out  1  1 = store.
- `mem_req_wmask`  out  4  byte-lane enables (stores); 0000 for loads.
- `mem_req_wdata`  out  DATA_WIDTH  lane-positioned store data.
- `mem_resp_valid`  in  1  response/ack for the accepted request.
- `mem_resp_rdata`  in  DATA_WIDTH  full aligned word (loads).
- `rf_wen`  out  1  register write enable.
- `rf_waddr`  out  ADDR_WIDTH  register write index.
- `rf_wdata`  out  DATA_WIDTH  register write data.
- `done`  out  1  one-cycle pulse: op retired.
- `err`  out  1  one-cycle pulse: misaligned or illegal funct3, op dropped.

## Operation
- States: IDLE, REQ, WAIT, WB.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch addr, wdata, rd, funct3 and is_load.
  - Illegal funct3, halfword at odd address, or word at `addr[1:0]`≠0: pulse `err` next cycle, stay in IDLE, no memory access.
  - Otherwise go to REQ.
- **REQ**
  - `mem_req_valid`=1 with stable fields until `mem_req_ready`, then go to WAIT.
- **WAIT**
  - On `mem_resp_valid`, latch the response and go to WB.
  - `mem_resp_valid` is ignored in every state other than WAIT.
- **WB**
  - One cycle. `done`=1.
  - For a load, `rf_wen`=1 unless rd=0 (`rf_wen` forced 0 for rd=0).
  - Then go to IDLE.
- Store lanes, with o = `addr[1:0]`:
  - SB: wmask = 0001<<o, wdata = {4{byte}}.
  - SH: wmask = 0011<<o, wdata = {2{half}}.
  - SW: wmask = 1111, wdata = data.
- Load extraction:
  - Shift `rdata` right by 8·o.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- `rf_wdata`/`rf_waddr` hold the last values outside WB; only `rf_wen` qualifies them.

## Timing
- Reset (asynchronous, any state): state = IDLE. All outputs 0 except `req_ready`=1. Latched fields cleared.
  - A response arriving after reset is ignored, because IDLE ignores `mem_resp_valid`.
- Handshakes complete on a rising edge with valid & ready both high.
- `mem_req_valid` must not drop once raised until accepted.
- Best-case cycle numbering, with accept at edge 0:
  - `mem_req_valid` high in cycle 1.
  - `mem_req_ready` in cycle 1 moves to WAIT in cycle 2.
  - `mem_resp_valid` in cycle 2 moves to WB in cycle 3, where `rf_wen`/`done` are high.
  - Best-case accept-to-writeback is therefore 3 cycles.
- Throughput: at most one op per 4 cycles. `req_ready` returns in the cycle after WB.
- Memory never asserts a response in the same cycle as its request handshake. A response in that cycle is ignored.
- `err` fires one cycle after acceptance; `req_ready` stays 1 throughout.

## Test plan
- LW addr 0x80000004; mem ready immediately; resp 0xDEADBEEF the cycle after → `mem_req_addr`=0x80000004, `mem_req_wmask`=0000, `rf_wen`=1, `rf_waddr`=rd, `rf_wdata`=0xDEADBEEF exactly 3 cycles after accept, `done` 1 cycle.
- LB/LBU addr 0x...3 with rdata 0x80FF7F01 → LB gives 0xFFFFFF80, LBU gives 0x00000080. LH addr 0x...2 gives 0xFFFF80FF; LHU gives 0x000080FF.
- SB addr 0x...1, data 0x000000AB → wmask 0010, wdata 0xABABABAB, `mem_req_wen`=1. On ack: `done`=1, `rf_wen`=0.
- LH at 0x...1 and SW at 0x...2 → `err` pulse, `mem_req_valid` never asserted, `req_ready` stays 1.
- `mem_req_ready` held low 5 cycles → `mem_req_valid` and all request fields stable all 5 cycles. A spurious `mem_resp_valid` during REQ has no effect.
- Load to rd=0 → `done`=1, `rf_wen`=0. Separately, assert `rst_n`=0 in WAIT then release, then give a late response → outputs reset immediately, late response is ignored, and the next op completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
// Multi-cycle load/store unit feeding the register file write port.
// Accepts one memory op at a time from execute, issues a single valid/ready
// memory request, waits for the response and retires the op. Loads are
// lane-aligned and sign/zero-extended into an rf write; stores drive
// byte-lane masked writes. Illegal funct3 or misaligned accesses are dropped
// with a one-cycle err pulse and never reach memory.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      execute-side handshake (ready only in IDLE)
//   req_is_load_i, req_funct3_i    op kind and RV32I width encoding
//   req_addr_i, req_wdata_i        byte address and store data
//   req_rd_i                       load destination register
//   mem_req_valid_o / _ready_i     memory request handshake
//   mem_req_addr_o                 word-aligned address
//   mem_req_wen_o, mem_req_wmask_o store enable and byte-lane mask
//   mem_req_wdata_o                lane-positioned store data
//   mem_resp_valid_i, _rdata_i     memory response (honoured only in WAIT)
//   rf_wen_o, rf_waddr_o, rf_wdata_o  register file write triple
//   done_o, err_o                  one-cycle retire / drop pulses
module load_store_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_is_load_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [ADDR_WIDTH-1:0] req_rd_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [DATA_WIDTH-1:0] mem_req_addr_o,
    output logic                  mem_req_wen_o,
    output logic [3:0]            mem_req_wmask_o,
    output logic [DATA_WIDTH-1:0] mem_req_wdata_o,
    input  logic                  mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata_i,
    output logic                  rf_wen_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0]   rd_q, rd_d;
    logic [2:0]              funct3_q, funct3_d;
    logic                    isLoad_q, isLoad_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   rfWaddr_q, rfWaddr_d;
    logic [DATA_WIDTH-1:0]   rfWdata_q, rfWdata_d;

    logic                    funct3Legal;
    logic                    misaligned;
    logic [DATA_WIDTH-1:0]   shifted;
    logic [DATA_WIDTH-1:0]   loadData;
    logic [3:0]              laneMask;
    logic [DATA_WIDTH-1:0]   laneData;

    // Incoming op check: unsigned widths exist only for loads, and halfword /
    // word accesses must sit on their natural boundary.
    always_comb begin
        funct3Legal = 1'b0;
        case (req_funct3_i)
            3'b000, 3'b001, 3'b010: funct3Legal = 1'b1;
            3'b100, 3'b101:         funct3Legal = req_is_load_i;
            default:                funct3Legal = 1'b0;
        endcase
        misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                     ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend
    // according to the width and signedness held in funct3.
    always_comb begin
        shifted  = mem_resp_rdata_i >> {addr_q[1:0], 3'b000};
        loadData = mem_resp_rdata_i;
        case (funct3_q)
            3'b000:  loadData = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b001:  loadData = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b100:  loadData = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            3'b101:  loadData = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: loadData = mem_resp_rdata_i;
        endcase
    end

    // Store lanes: replicating the data across the word lets memory pick
    // whichever lanes the mask enables without a data shifter.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                laneMask = 4'b0001 << addr_q[1:0];
                laneData = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                laneMask = 4'b0011 << addr_q[1:0];
                laneData = {2{wdata_q[15:0]}};
            end
            default: begin
                laneMask = 4'b1111;
                laneData = wdata_q;
            end
        endcase
    end

    // Next-state logic. Fields are latched on every accepted op, even ones
    // that are then dropped, and the rf data register only changes when a
    // load response arrives so its value holds between writebacks.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        funct3_d  = funct3_q;
        isLoad_d  = isLoad_q;
        err_d     = 1'b0;
        rfWaddr_d = rfWaddr_q;
        rfWdata_d = rfWdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    rd_d     = req_rd_i;
                    funct3_d = req_funct3_i;
                    isLoad_d = req_is_load_i;
                    if (funct3Legal && !misaligned) begin
                        state_d = REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid_i) begin
                    state_d = WB;
                    if (isLoad_q) begin
                        rfWaddr_d = rd_q;
                        rfWdata_d = loadData;
                    end
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-field registers; reset returns to IDLE with all
    // captured fields cleared.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            funct3_q  <= '0;
            isLoad_q  <= 1'b0;
            err_q     <= 1'b0;
            rfWaddr_q <= '0;
            rfWdata_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            funct3_q  <= funct3_d;
            isLoad_q  <= isLoad_d;
            err_q     <= err_d;
            rfWaddr_q <= rfWaddr_d;
            rfWdata_q <= rfWdata_d;
        end
    end

    // Outputs are decoded from state; request fields come straight from the
    // latched op so they stay stable for as long as REQ lasts.
    always_comb begin
        req_ready_o     = (state_q == IDLE);
        mem_req_valid_o = (state_q == REQ);
        mem_req_addr_o  = '0;
        mem_req_wen_o   = 1'b0;
        mem_req_wmask_o = 4'b0000;
        mem_req_wdata_o = '0;
        if (state_q == REQ) begin
            mem_req_addr_o = {addr_q[DATA_WIDTH-1:2], 2'b00};
            if (!isLoad_q) begin
                mem_req_wen_o   = 1'b1;
                mem_req_wmask_o = laneMask;
                mem_req_wdata_o = laneData;
            end
        end
        rf_wen_o   = (state_q == WB) && isLoad_q && (rd_q != '0);
        rf_waddr_o = rfWaddr_q;
        rf_wdata_o = rfWdata_q;
        done_o     = (state_q == WB);
        err_o      = err_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Drives directed and randomized memory ops into load_store_unit, acts as
// the memory, and compares every observable output against a reference
// model computed from the byte-lane rules with plain arithmetic.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_load;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [3:0]  mem_req_wmask;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        done;
    logic        err;

    int          errorCount = 0;
    int          checkCount = 0;
    logic [31:0] lastRfData = 32'h0;

    load_store_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_is_load_i   (req_is_load),
        .req_funct3_i    (req_funct3),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .req_rd_i        (req_rd),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_req_wen_o   (mem_req_wen),
        .mem_req_wmask_o (mem_req_wmask),
        .mem_req_wdata_o (mem_req_wdata),
        .mem_resp_valid_i(mem_resp_valid),
        .mem_resp_rdata_i(mem_resp_rdata),
        .rf_wen_o        (rf_wen),
        .rf_waddr_o      (rf_waddr),
        .rf_wdata_o      (rf_wdata),
        .done_o          (done),
        .err_o           (err)
    );

    // Free-running clock; all driving and sampling happens on the falling edge.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: access size in bytes, or 0 when the funct3 is not legal.
    function automatic int modelSize(input bit isLoad, input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: modelSize = (isLoad || f3 == 3'd0) ? 1 : 0;
            3'd1, 3'd5: modelSize = (isLoad || f3 == 3'd1) ? 2 : 0;
            3'd2:       modelSize = 4;
            default:    modelSize = 0;
        endcase
    endfunction

    // Reference: value a load writes back, from the byte offset and width.
    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        logic [31:0] v;
        logic [31:0] b;
        logic [31:0] h;
        v = rdata >> (8 * (addr % 4));
        b = v & 32'hFF;
        h = v & 32'hFFFF;
        case (f3)
            3'd0:    modelLoad = (b >= 32'd128) ? b - 32'd256 : b;
            3'd1:    modelLoad = (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    modelLoad = b;
            3'd5:    modelLoad = h;
            default: modelLoad = rdata;
        endcase
    endfunction

    // Reference: store byte mask, one bit per byte covered by the access.
    function automatic logic [3:0] modelMask(input int size, input logic [31:0] addr);
        int o;
        o = int'(addr % 4);
        modelMask = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (k >= o && k < o + size) modelMask[k] = 1'b1;
        end
    endfunction

    // Reference: store data with the low `size` bytes repeated in every lane.
    function automatic logic [31:0] modelStoreData(input int size, input logic [31:0] data);
        modelStoreData = 32'h0;
        for (int k = 0; k < 4; k++) begin
            modelStoreData = modelStoreData | (((data >> (8 * (k % size))) & 32'hFF) << (8 * k));
        end
    endfunction

    // Runs one op end to end, playing the memory side with the given
    // ready/response delays, and checks each cycle against the model.
    task automatic applyStimulus(input bit isLoad, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd,
                                 input int readyDelay, input int respDelay,
                                 input logic [31:0] rdata, input bit spurious);
        int          size;
        logic [31:0] expData;
        size = modelSize(isLoad, f3);
        if (size != 0 && (addr % size) != 0) size = 0;

        @(negedge clk);
        checkOutput("ready_idle", req_ready, 1);
        req_valid   = 1'b1;
        req_is_load = isLoad;
        req_funct3  = f3;
        req_addr    = addr;
        req_wdata   = wdata;
        req_rd      = rd;
        @(negedge clk);
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);

        if (size == 0) begin
            checkOutput("err_pulse", err, 1);
            checkOutput("err_no_mem", mem_req_valid, 0);
            checkOutput("err_ready", req_ready, 1);
            @(negedge clk);
            checkOutput("err_clear", err, 0);
            checkOutput("err_no_mem2", mem_req_valid, 0);
            checkOutput("err_ready2", req_ready, 1);
            return;
        end

        checkOutput("no_err", err, 0);
        for (int i = 0; i <= readyDelay; i++) begin
            checkOutput("req_valid", mem_req_valid, 1);
            checkOutput("req_addr", mem_req_addr, addr & 32'hFFFF_FFFC);
            checkOutput("req_wen", mem_req_wen, !isLoad);
            checkOutput("req_ready_busy", req_ready, 0);
            if (isLoad) begin
                checkOutput("req_wmask_ld", mem_req_wmask, 0);
            end else begin
                checkOutput("req_wmask", mem_req_wmask, modelMask(size, addr));
                checkOutput("req_wdata", mem_req_wdata, modelStoreData(size, wdata));
            end
            mem_req_ready  = (i == readyDelay);
            mem_resp_valid = spurious;
            mem_resp_rdata = $urandom;
            @(negedge clk);
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;

        for (int j = 0; j <= respDelay; j++) begin
            checkOutput("wait_no_req", mem_req_valid, 0);
            checkOutput("wait_no_done", done, 0);
            if (j == respDelay) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = rdata;
            end
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        mem_resp_rdata = $urandom;

        expData = modelLoad(f3, addr, rdata);
        checkOutput("wb_done", done, 1);
        checkOutput("wb_ready", req_ready, 0);
        checkOutput("wb_rf_wen", rf_wen, isLoad && rd != 0);
        if (isLoad) begin
            checkOutput("wb_rf_waddr", rf_waddr, rd);
            checkOutput("wb_rf_wdata", rf_wdata, expData);
            lastRfData = expData;
        end
        @(negedge clk);
        checkOutput("post_done", done, 0);
        checkOutput("post_rf_wen", rf_wen, 0);
        checkOutput("post_ready", req_ready, 1);
        if (isLoad) checkOutput("post_rf_hold", rf_wdata, lastRfData);
    endtask

    initial begin
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_is_load    = 1'b0;
        req_funct3     = 3'd0;
        req_addr       = 32'h0;
        req_wdata      = 32'h0;
        req_rd         = 5'd0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;

        @(negedge clk);
        checkOutput("rst_ready", req_ready, 1);
        checkOutput("rst_mem_valid", mem_req_valid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_rf_wen", rf_wen, 0);
        checkOutput("rst_rf_wdata", rf_wdata, 0);
        rst_n = 1'b1;

        // Directed cases with fixed expected values.
        applyStimulus(1, 3'b010, 32'h8000_0004, 32'h0, 5'd5, 0, 0, 32'hDEAD_BEEF, 0);
        checkOutput("lw_value", lastRfData, 32'hDEAD_BEEF);
        applyStimulus(1, 3'b000, 32'h0000_1003, 32'h0, 5'd6, 0, 0, 32'h80FF_7F01, 0);
        checkOutput("lb_value", lastRfData, 32'hFFFF_FF80);
        applyStimulus(1, 3'b100, 32'h0000_1003, 32'h0, 5'd7, 1, 1, 32'h80FF_7F01, 0);
        checkOutput("lbu_value", lastRfData, 32'h0000_0080);
        applyStimulus(1, 3'b001, 32'h0000_1002, 32'h0, 5'd8, 0, 2, 32'h80FF_7F01, 0);
        checkOutput("lh_value", lastRfData, 32'hFFFF_80FF);
        applyStimulus(1, 3'b101, 32'h0000_1002, 32'h0, 5'd9, 2, 0, 32'h80FF_7F01, 0);
        checkOutput("lhu_value", lastRfData, 32'h0000_80FF);
        checkOutput("sb_mask_model", modelMask(1, 32'h1), 4'b0010);
        applyStimulus(0, 3'b000, 32'h0000_2001, 32'h0000_00AB, 5'd3, 0, 0, 32'h0, 0);
        applyStimulus(1, 3'b001, 32'h0000_3001, 32'h0, 5'd4, 0, 0, 32'h0, 0);
        applyStimulus(0, 3'b010, 32'h0000_3002, 32'h1234_5678, 5'd4, 0, 0, 32'h0, 0);
        applyStimulus(0, 3'b001, 32'h0000_4002, 32'hCAFE_F00D, 5'd0, 5, 2, 32'h0, 1);
        applyStimulus(1, 3'b010, 32'h0000_4008, 32'h0, 5'd0, 0, 0, 32'h5555_AAAA, 0);

        // Reset while waiting for a response; the late response must be ignored.
        @(negedge clk);
        req_valid   = 1'b1;
        req_is_load = 1'b1;
        req_funct3  = 3'b010;
        req_addr    = 32'h0000_5000;
        req_rd      = 5'd10;
        @(negedge clk);
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        checkOutput("rst_wait_in_wait", mem_req_valid, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_ready", req_ready, 1);
        checkOutput("arst_rf_wdata", rf_wdata, 0);
        checkOutput("arst_rf_waddr", rf_waddr, 0);
        checkOutput("arst_done", done, 0);
        lastRfData = 32'h0;
        @(negedge clk);
        rst_n          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        checkOutput("late_resp_done", done, 0);
        checkOutput("late_resp_rf_wen", rf_wen, 0);
        checkOutput("late_resp_rf_wdata", rf_wdata, 0);
        checkOutput("late_resp_ready", req_ready, 1);
        applyStimulus(1, 3'b010, 32'h0000_5004, 32'h0, 5'd11, 0, 0, 32'h0BAD_F00D, 0);

        // Randomized ops, including illegal widths and misaligned addresses.
        for (int n = 0; n < 80; n++) begin
            bit          ld;
            bit          sp;
            int          rdy;
            int          rsp;
            ld  = 1'($urandom);
            sp  = ($urandom_range(0, 3) == 0);
            rdy = $urandom_range(0, 3);
            rsp = sp ? $urandom_range(1, 3) : $urandom_range(0, 3);
            applyStimulus(ld, 3'($urandom_range(0, 7)), $urandom, $urandom,
                          5'($urandom), rdy, rsp, $urandom, sp);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
